// File: rtl/crack_pkg.sv
// Shared types for the ARC4 crack scheduler: key width, key type and scheduler states.
package crack_pkg;

  localparam int KEY_W = 24;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/crack_scheduler_core_pick.sv
// Lowest-index priority pick over cores that report ready and are not already holding a key.
module core_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] core_rdy_i,
  input  logic [N-1:0] busy_i,
  output logic [N-1:0] grant_o,
  output logic         any_o
);

  logic [N-1:0] cand;

  assign cand  = core_rdy_i & ~busy_i;
  assign any_o = |cand;

  // Walk from the top down so the lowest candidate is written last and wins.
  always_comb begin
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crack_scheduler.sv
// Hands ascending ARC4 keys to free crack cores and keeps the smallest hit.
// Optional CRACK_SCHED_PROGRESS_EN adds a saturating completed-candidate counter on `progress`.
module crack_scheduler
  import crack_pkg::*;
#(
  parameter int   NUM_CORES = 2,
  parameter key_t KEY_MAX   = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rdy,
  input  logic [NUM_CORES-1:0] core_rdy,
  output logic [NUM_CORES-1:0] core_en,
  output key_t [NUM_CORES-1:0] core_key,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_hit,
  output key_t                 key,
  output logic                 key_valid,
  output logic                 done
`ifdef CRACK_SCHED_PROGRESS_EN
  ,
  output key_t                 progress
`endif
);

  // IDLE: wait for en | DISPATCH: issue keys | DRAIN: wait for outstanding=0 | FINISH: raise done
  localparam int OUT_W = $clog2(NUM_CORES + 1);
  localparam int NK_W  = KEY_W + 1;

  sched_state_t                 state_q, state_d;
  logic         [NK_W-1:0]      next_key_q, next_key_d;
  logic         [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic         [NUM_CORES-1:0] busy_q, busy_d;
  logic         [NUM_CORES-1:0] core_en_q, core_en_d;
  key_t         [NUM_CORES-1:0] core_key_q, core_key_d;
  key_t                         key_q, key_d;
  logic                         key_valid_q, key_valid_d;
  logic                         done_q, done_d;

  logic         [NUM_CORES-1:0] grant;
  logic                         any_free;
  logic         [NUM_CORES-1:0] retire;
  logic         [OUT_W-1:0]     n_ret;
  logic                         hit_any;
  key_t                         best;
  logic                         dispatch;

  core_pick #(.N(NUM_CORES)) u_pick (
    .core_rdy_i (core_rdy),
    .busy_i     (busy_q),
    .grant_o    (grant),
    .any_o      (any_free)
  );

  // Results from cores we never dispatched to are dropped here.
  assign retire = core_done & busy_q;

  always_comb begin
    state_d       = state_q;
    next_key_d    = next_key_q;
    outstanding_d = outstanding_q;
    busy_d        = busy_q;
    core_en_d     = '0;
    core_key_d    = core_key_q;
    key_d         = key_q;
    key_valid_d   = key_valid_q;
    done_d        = done_q;
    n_ret         = '0;
    hit_any       = key_valid_q;
    best          = key_q;
    dispatch      = (state_q == DISPATCH) && any_free;

    if (state_q == DISPATCH || state_q == DRAIN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (retire[i]) begin
          busy_d[i] = 1'b0;
          n_ret     = n_ret + OUT_W'(1);
          if (core_hit[i] && (!hit_any || core_key_q[i] < best)) begin
            best    = core_key_q[i];
            hit_any = 1'b1;
          end
        end
      end
      key_d       = best;
      key_valid_d = hit_any;
    end

    if (dispatch) begin
      core_en_d  = grant;
      busy_d     = busy_d | grant;
      next_key_d = next_key_q + NK_W'(1);
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant[i]) core_key_d[i] = next_key_q[KEY_W-1:0];
      end
    end

    outstanding_d = outstanding_q + OUT_W'(dispatch) - n_ret;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d       = DISPATCH;
          next_key_d    = '0;
          outstanding_d = '0;
          busy_d        = '0;
          key_d         = '0;
          key_valid_d   = 1'b0;
          done_d        = 1'b0;
        end
      end
      DISPATCH: begin
        if ((hit_any && !key_valid_q) || (dispatch && next_key_q == {1'b0, KEY_MAX}))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (outstanding_d == '0) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      next_key_q    <= '0;
      outstanding_q <= '0;
      busy_q        <= '0;
      core_en_q     <= '0;
      core_key_q    <= '0;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_key_q    <= next_key_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      core_en_q     <= core_en_d;
      core_key_q    <= core_key_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      done_q        <= done_d;
    end
  end

  assign rdy       = (state_q == IDLE);
  assign core_en   = core_en_q;
  assign core_key  = core_key_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign done      = done_q;

`ifdef CRACK_SCHED_PROGRESS_EN
  key_t            progress_q, progress_d;
  logic [NK_W-1:0] progress_sum;

  always_comb begin
    progress_d   = progress_q;
    progress_sum = {1'b0, progress_q} + NK_W'(n_ret);
    if (state_q == IDLE && en)
      progress_d = '0;
    else if (state_q == DISPATCH || state_q == DRAIN)
      progress_d = progress_sum[KEY_W] ? '1 : progress_sum[KEY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) progress_q <= '0;
    else     progress_q <= progress_d;
  end

  assign progress = progress_q;
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
// Scoreboard bench: two schedulers (full key space and KEY_MAX=0xF) driven by behavioural cores.
`timescale 1ns/1ps
module tb_crack_scheduler;
  import crack_pkg::*;

  localparam int   NC    = 2;
  localparam key_t KMAX0 = 24'hFFFFFF;
  localparam key_t KMAX1 = 24'h00000F;

  typedef struct {
    int d;
    bit valid;
    int key;
    int bound;
    int n_disp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              en        [2];
  logic              rdy       [2];
  logic [NC-1:0]     core_rdy  [2];
  logic [NC-1:0]     core_en   [2];
  key_t [NC-1:0]     core_key  [2];
  logic [NC-1:0]     core_done [2];
  logic [NC-1:0]     core_hit  [2];
  key_t              key       [2];
  logic              key_valid [2];
  logic              done      [2];
`ifdef CRACK_SCHED_PROGRESS_EN
  key_t              progress  [2];
`endif

  always #5 clk = ~clk;

  crack_scheduler #(.NUM_CORES(NC), .KEY_MAX(KMAX0)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]),
    .core_rdy(core_rdy[0]), .core_en(core_en[0]), .core_key(core_key[0]),
    .core_done(core_done[0]), .core_hit(core_hit[0]),
    .key(key[0]), .key_valid(key_valid[0]), .done(done[0])
`ifdef CRACK_SCHED_PROGRESS_EN
    , .progress(progress[0])
`endif
  );

  crack_scheduler #(.NUM_CORES(NC), .KEY_MAX(KMAX1)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]),
    .core_rdy(core_rdy[1]), .core_en(core_en[1]), .core_key(core_key[1]),
    .core_done(core_done[1]), .core_hit(core_hit[1]),
    .key(key[1]), .key_valid(key_valid[1]), .done(done[1])
`ifdef CRACK_SCHED_PROGRESS_EN
    , .progress(progress[1])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Search configuration shared by the core model and the reference model.
  bit   hit_set [int];
  int   lat_of  [int];
  int   base_lat = 4;
  exp_t sb_q [$];

  function automatic int lat_fn(int k);
    return lat_of.exists(k) ? lat_of[k] : base_lat;
  endfunction

  // Behavioural cores: take a key on core_en, answer after its latency.
  int timer    [2][NC];
  int ckey     [2][NC];
  bit run_c    [2][NC];
  int done_cnt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        core_rdy[d]  = '1;
        core_done[d] = '0;
        core_hit[d]  = '0;
        done_cnt[d]  = 0;
        for (int i = 0; i < NC; i++) run_c[d][i] = 1'b0;
      end else begin
        if (en[d] && rdy[d]) done_cnt[d] = 0;
        for (int i = 0; i < NC; i++) begin
          core_done[d][i] = 1'b0;
          core_hit[d][i]  = 1'b0;
          if (run_c[d][i]) begin
            timer[d][i]--;
            if (timer[d][i] == 0) begin
              run_c[d][i]     = 1'b0;
              core_done[d][i] = 1'b1;
              core_hit[d][i]  = hit_set.exists(ckey[d][i]);
              core_rdy[d][i]  = 1'b1;
              done_cnt[d]++;
            end
          end
          if (core_en[d][i]) begin
            ckey[d][i]     = int'(core_key[d][i]);
            timer[d][i]    = lat_fn(ckey[d][i]);
            run_c[d][i]    = 1'b1;
            core_rdy[d][i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: dispatch order and scoreboard pop on each rising done.
  int exp_next [2];
  int n_disp   [2];
  int last_key [2];
  bit done_prev[2];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_next[d]  = 0;
        n_disp[d]    = 0;
        last_key[d]  = -1;
        done_prev[d] = 1'b0;
      end else begin
        if (en[d] && rdy[d]) begin
          exp_next[d] = 0;
          n_disp[d]   = 0;
          last_key[d] = -1;
        end
        if (core_en[d] != '0) begin
          check($sformatf("dispatch_onehot%0d", d), $countones(core_en[d]), 1);
          for (int i = 0; i < NC; i++) begin
            if (core_en[d][i]) begin
              check($sformatf("dispatch_key%0d", d), core_key[d][i], exp_next[d]);
              exp_next[d]++;
              n_disp[d]++;
              last_key[d] = int'(core_key[d][i]);
            end
          end
        end
        if (done[d] && !done_prev[d]) begin
          if (sb_q.size() == 0) begin
            check($sformatf("unexpected_done%0d", d), 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("done_dut_idx", d, e.d);
            check("key_valid", key_valid[d], e.valid);
            check("key", key[d], e.key);
            check("last_key_bound", (last_key[d] <= e.bound), 1);
            check("rdy_at_done", rdy[d], 1);
            if (e.n_disp >= 0) check("dispatch_count", n_disp[d], e.n_disp);
`ifdef CRACK_SCHED_PROGRESS_EN
            check("progress", progress[d], done_cnt[d]);
`endif
          end
        end
        done_prev[d] = done[d];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic pulse_en(int d);
    @(posedge clk); #1 en[d] = 1'b1;
    @(posedge clk); #1 en[d] = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_rdy%0d", tag, d), rdy[d], 1);
      check($sformatf("%s_core_en%0d", tag, d), core_en[d], 0);
      check($sformatf("%s_core_key%0d", tag, d), core_key[d], 0);
      check($sformatf("%s_key%0d", tag, d), key[d], 0);
      check($sformatf("%s_key_valid%0d", tag, d), key_valid[d], 0);
      check($sformatf("%s_done%0d", tag, d), done[d], 0);
    end
  endtask

  // Reference: smallest hitting key within the searched range, else exhaustive count.
  task automatic run_search(int d, int bound, int budget);
    exp_t e;
    int   best = -1;
    int   km   = (d == 0) ? int'(KMAX0) : int'(KMAX1);
    foreach (hit_set[k]) if (k <= km && (best < 0 || k < best)) best = k;
    e.d      = d;
    e.valid  = (best >= 0);
    e.key    = (best >= 0) ? best : 0;
    e.bound  = bound;
    e.n_disp = (best < 0) ? km + 1 : -1;
    sb_q.push_back(e);
    pulse_en(d);
    for (int c = 0; c < budget && sb_q.size() != 0; c++) @(posedge clk);
    if (sb_q.size() != 0) begin
      check($sformatf("timeout_dut%0d", d), 0, 1);
      sb_q.delete();
      do_reset();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic new_cfg(int lat);
    hit_set.delete();
    lat_of.delete();
    base_lat = lat;
  endtask

  initial begin
    en[0] = 1'b0;
    en[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("init");

    // Single hit deep in the search, 20-cycle cores.
    new_cfg(20); hit_set[24'h18] = 1'b1;
    run_search(0, 24'h19, 3000);

    // Key 5 hits first while key 3 is still in flight; 3 must win.
    new_cfg(6); hit_set[3] = 1'b1; hit_set[5] = 1'b1; lat_of[3] = 40;
    run_search(1, 5, 2000);

    // Exhaust KEY_MAX=0xF with no hit.
    new_cfg(3);
    run_search(1, 15, 2000);

    // Keys 8 and 9 complete and hit in the same cycle.
    new_cfg(5); hit_set[8] = 1'b1; hit_set[9] = 1'b1; lat_of[8] = 6;
    run_search(1, 9, 2000);

    for (int it = 0; it < 8; it++) begin
      int d  = it % 2;
      int nh = $urandom_range(3, (d == 0) ? 1 : 0);
      new_cfg($urandom_range(8, 1));
      for (int k = 0; k <= 20; k++) lat_of[k] = $urandom_range(12, 1);
      for (int h = 0; h < nh; h++) hit_set[$urandom_range((d == 0) ? 20 : 15, 0)] = 1'b1;
      run_search(d, (d == 0) ? int'(KMAX0) : int'(KMAX1), 3000);
    end

    // Abort a search around cycle 50, then restart from key 0.
    new_cfg(3); hit_set[1000] = 1'b1;
    pulse_en(0);
    repeat (48) @(posedge clk);
    do_reset();
    @(negedge clk);
    check_reset_vals("midrst");
    new_cfg(3); hit_set[2] = 1'b1;
    run_search(0, 3, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
